axis_lfsr_checker: RTL

- Downstream consumer of the 64-bit free-running LFSR test-pattern stream.
- Self-synchronises to the incoming pattern, then flywheels its own prediction and counts word and bit errors.
- Used for link/DMA/FIFO integrity (BER) tests.
- Status counters are exposed to the status register bank.

---
 rtl/axis_lfsr_checker_pkg.sv | 20 ++
 rtl/axis_lfsr_checker_popcount.sv | 25 ++
 rtl/axis_lfsr_checker.sv | 130 +++++++++++++
 3 files changed

// File: rtl/axis_lfsr_checker_pkg.sv
// Shared LFSR pattern definitions for the test-pattern generator and checker.
// Holds the state encoding, the step function and the generator seed.
package axis_lfsr_checker_pkg;

  localparam int unsigned LFSR_W = 64;
  localparam int unsigned POP_W  = 7;
  localparam int unsigned RUN_W  = 8;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 64'h5555_5555_5555_5555;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] x);
    return {x[62:0], ~(x[62] ^ x[61])};
  endfunction

endpackage

// File: rtl/axis_lfsr_checker_popcount.sv
// Combinational 64-bit population count built as a balanced adder tree.
// Zero latency; no flow control.
module axis_lfsr_popcount
  import axis_lfsr_checker_pkg::*;
(
  input  logic [LFSR_W-1:0] in_dat,
  output logic [POP_W-1:0]  cnt_dat
);

  logic [1:0] lvl1 [32];
  logic [2:0] lvl2 [16];
  logic [3:0] lvl3 [8];
  logic [4:0] lvl4 [4];
  logic [5:0] lvl5 [2];

  always_comb begin
    for (int i = 0; i < 32; i++) lvl1[i] = {1'b0, in_dat[2*i]} + {1'b0, in_dat[2*i+1]};
    for (int i = 0; i < 16; i++) lvl2[i] = {1'b0, lvl1[2*i]} + {1'b0, lvl1[2*i+1]};
    for (int i = 0; i < 8; i++)  lvl3[i] = {1'b0, lvl2[2*i]} + {1'b0, lvl2[2*i+1]};
    for (int i = 0; i < 4; i++)  lvl4[i] = {1'b0, lvl3[2*i]} + {1'b0, lvl3[2*i+1]};
    for (int i = 0; i < 2; i++)  lvl5[i] = {1'b0, lvl4[2*i]} + {1'b0, lvl4[2*i+1]};
    cnt_dat = {1'b0, lvl5[0]} + {1'b0, lvl5[1]};
  end

endmodule

// File: rtl/axis_lfsr_checker.sv
// LFSR pattern checker: self-syncs in HUNT, flywheels in LOCKED, counts word/bit errors.
// Status updates on the accepting edge (visible next cycle); never back-pressures.
module axis_lfsr_checker
  import axis_lfsr_checker_pkg::*;
#(
  parameter int unsigned AXIS_TDATA_WIDTH = 64,
  parameter int unsigned CNTR_WIDTH       = 32,
  parameter int unsigned LOCK_COUNT       = 8,
  parameter int unsigned LOSS_COUNT       = 4
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic                        cfg_clear,
  output logic                        sts_locked,
  output logic [CNTR_WIDTH-1:0]       sts_word_cntr,
  output logic [CNTR_WIDTH-1:0]       sts_word_err_cntr,
  output logic [CNTR_WIDTH-1:0]       sts_bit_err_cntr
);

  localparam int unsigned SUM_W = ((CNTR_WIDTH > POP_W) ? CNTR_WIDTH : POP_W) + 1;
  localparam logic [CNTR_WIDTH-1:0] CNTR_MAX = '1;

  state_e                  state_q, state_d;
  logic [LFSR_W-1:0]       pred_q, pred_d;
  logic                    pred_valid_q, pred_valid_d;
  logic [RUN_W-1:0]        good_run_q, good_run_d;
  logic [RUN_W-1:0]        err_run_q, err_run_d;
  logic [CNTR_WIDTH-1:0]   word_q, word_d;
  logic [CNTR_WIDTH-1:0]   word_err_q, word_err_d;
  logic [CNTR_WIDTH-1:0]   bit_err_q, bit_err_d;
  logic                    tready_q, tready_d;

  logic                    beat;
  logic [LFSR_W-1:0]       diff;
  logic [POP_W-1:0]        diff_bits;
  logic [SUM_W-1:0]        bit_sum;

  assign beat = s_axis_tvalid & tready_q;
  assign diff = s_axis_tdata ^ pred_q;

  axis_lfsr_popcount u_popcount (
    .in_dat  (diff),
    .cnt_dat (diff_bits)
  );

  always_comb begin
    state_d      = state_q;
    pred_d       = pred_q;
    pred_valid_d = pred_valid_q;
    good_run_d   = good_run_q;
    err_run_d    = err_run_q;
    word_d       = word_q;
    word_err_d   = word_err_q;
    bit_err_d    = bit_err_q;
    tready_d     = 1'b1;
    bit_sum      = SUM_W'(bit_err_q) + SUM_W'(diff_bits);

    if (beat) begin
      case (state_q)
        ST_HUNT: begin
          good_run_d   = (pred_valid_q && diff == '0) ? good_run_q + 1'b1 : '0;
          pred_d       = lfsr_step(s_axis_tdata);
          pred_valid_d = 1'b1;
          if (good_run_d == RUN_W'(LOCK_COUNT)) begin
            state_d   = ST_LOCKED;
            err_run_d = '0;
          end
        end
        ST_LOCKED: begin
          // Flywheel: prediction advances from itself, so one bad word costs one error.
          pred_d = lfsr_step(pred_q);
          word_d = (word_q != CNTR_MAX) ? word_q + 1'b1 : word_q;
          if (diff != '0) begin
            word_err_d = (word_err_q != CNTR_MAX) ? word_err_q + 1'b1 : word_err_q;
            bit_err_d  = (bit_sum > SUM_W'(CNTR_MAX)) ? CNTR_MAX : bit_sum[CNTR_WIDTH-1:0];
            err_run_d  = err_run_q + 1'b1;
          end else begin
            err_run_d = '0;
          end
          if (err_run_d == RUN_W'(LOSS_COUNT)) begin
            state_d    = ST_HUNT;
            good_run_d = '0;
            pred_d     = lfsr_step(s_axis_tdata);
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

    if (cfg_clear) begin
      word_d     = '0;
      word_err_d = '0;
      bit_err_d  = '0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_HUNT;
      pred_q       <= '0;
      pred_valid_q <= 1'b0;
      good_run_q   <= '0;
      err_run_q    <= '0;
      word_q       <= '0;
      word_err_q   <= '0;
      bit_err_q    <= '0;
      tready_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pred_q       <= pred_d;
      pred_valid_q <= pred_valid_d;
      good_run_q   <= good_run_d;
      err_run_q    <= err_run_d;
      word_q       <= word_d;
      word_err_q   <= word_err_d;
      bit_err_q    <= bit_err_d;
      tready_q     <= tready_d;
    end
  end

  assign s_axis_tready     = tready_q;
  assign sts_locked        = (state_q == ST_LOCKED);
  assign sts_word_cntr     = word_q;
  assign sts_word_err_cntr = word_err_q;
  assign sts_bit_err_cntr  = bit_err_q;

endmodule
